// File: rtl/postadder_bank.sv
// NCH independent accumulator channels, each a DEPTH-entry register file updated by a
// per-channel opcode through one operand pipeline stage, with a bulk-clear FSM and read port.
module postadder_bank #(
    parameter int unsigned NCH    = 3,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 256,
    parameter logic [DATA_W-1:0] P =
        DATA_W'(256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47),
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [3*NCH-1:0]    op,
    input  logic [AW*NCH-1:0]   addr,
    input  logic                clr_start,
    output logic                busy,
    input  logic                rd_en,
    input  logic [CW-1:0]       rd_ch,
    input  logic [AW-1:0]       rd_addr,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NCH-1:0]      ovf
);

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpLoad = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpRsub = 3'b011;
    localparam logic [2:0] OpSub  = 3'b100;
    localparam logic [2:0] OpNeg  = 3'b101;
    localparam logic [2:0] OpClr  = 3'b110;
    localparam logic [2:0] OpFixp = 3'b111;

    localparam int unsigned Msb = DATA_W - 1;

    typedef enum logic [0:0] {StIdle, StClear} state_t;

    state_t             r_state;
    logic [AW-1:0]      r_cnt;

    logic [DATA_W-1:0]  r_mem   [NCH][DEPTH];
    logic [DATA_W-1:0]  w_mem_d [NCH][DEPTH];

    // Stage 1: operands already selected, result = a + (sub ? -b : b)
    logic [NCH-1:0]     r_s1_valid;
    logic [NCH-1:0]     r_s1_sub;
    logic [NCH-1:0]     r_s1_chk;
    logic [DATA_W-1:0]  r_s1_a    [NCH];
    logic [DATA_W-1:0]  r_s1_b    [NCH];
    logic [AW-1:0]      r_s1_addr [NCH];

    logic [2:0]         w_op      [NCH];
    logic [AW-1:0]      w_addr    [NCH];
    logic [DATA_W-1:0]  w_acc     [NCH];
    logic [DATA_W-1:0]  w_a_d     [NCH];
    logic [DATA_W-1:0]  w_b_d     [NCH];
    logic [NCH-1:0]     w_wr_d;
    logic [NCH-1:0]     w_sub_d;
    logic [NCH-1:0]     w_chk_d;

    logic [DATA_W-1:0]  w_b_eff   [NCH];
    logic [DATA_W-1:0]  w_res     [NCH];
    logic [NCH-1:0]     w_res_ovf;

    logic [NCH-1:0]     r_ovf;
    logic               r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;
    logic [DATA_W-1:0]  w_rd_data;

    logic               w_accept;
    logic               w_clr_go;

    assign in_ready = (r_state == StIdle) && !clr_start && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_clr_go = (r_state == StIdle) && clr_start;

    assign busy     = (r_state == StClear);
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign ovf      = r_ovf;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_b_eff[c]   = r_s1_sub[c] ? ~r_s1_b[c] : r_s1_b[c];
            w_res[c]     = r_s1_a[c] + w_b_eff[c] + DATA_W'(r_s1_sub[c]);
            w_res_ovf[c] = r_s1_chk[c] && (r_s1_a[c][Msb] == w_b_eff[c][Msb]) &&
                           (w_res[c][Msb] != r_s1_a[c][Msb]);
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_op[c]    = op[3*c +: 3];
            w_addr[c]  = addr[AW*c +: AW];
            // Forward the result being written this edge so back-to-back ops see it
            w_acc[c]   = (r_s1_valid[c] && (r_s1_addr[c] == w_addr[c])) ? w_res[c]
                                                                        : r_mem[c][w_addr[c]];
            w_a_d[c]   = '0;
            w_b_d[c]   = '0;
            w_sub_d[c] = 1'b0;
            w_chk_d[c] = 1'b0;
            w_wr_d[c]  = w_accept && (w_op[c] != OpNop);
            case (w_op[c])
                OpLoad: w_a_d[c] = in_data;
                OpAdd: begin
                    w_a_d[c]   = w_acc[c];
                    w_b_d[c]   = in_data;
                    w_chk_d[c] = 1'b1;
                end
                OpRsub: begin
                    w_a_d[c]   = in_data;
                    w_b_d[c]   = w_acc[c];
                    w_sub_d[c] = 1'b1;
                    w_chk_d[c] = 1'b1;
                end
                OpSub: begin
                    w_a_d[c]   = w_acc[c];
                    w_b_d[c]   = in_data;
                    w_sub_d[c] = 1'b1;
                    w_chk_d[c] = 1'b1;
                end
                OpNeg: begin
                    w_b_d[c]   = w_acc[c];
                    w_sub_d[c] = 1'b1;
                    w_chk_d[c] = 1'b1;
                end
                OpFixp: begin
                    w_a_d[c]   = w_acc[c];
                    w_b_d[c]   = w_acc[c][Msb] ? P : '0;
                    w_chk_d[c] = 1'b1;
                end
                OpNop, OpClr: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_mem_d = r_mem;
        for (int c = 0; c < NCH; c++) begin
            if (r_s1_valid[c]) begin
                w_mem_d[c][r_s1_addr[c]] = w_res[c];
            end
        end
        if (r_state == StClear) begin
            for (int c = 0; c < NCH; c++) begin
                w_mem_d[c][r_cnt] = '0;
            end
        end
    end

    // Read port is write-first: it sees everything committed at the same edge
    always_comb begin
        w_rd_data = '0;
        if (int'(rd_ch) < int'(NCH)) begin
            w_rd_data = w_mem_d[rd_ch][rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= '0;
            r_s1_sub   <= '0;
            r_s1_chk   <= '0;
            r_ovf      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_s1_a[c]    <= '0;
                r_s1_b[c]    <= '0;
                r_s1_addr[c] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[c][e] <= '0;
                end
            end
        end else begin
            r_mem      <= w_mem_d;
            r_s1_valid <= w_wr_d;
            r_s1_sub   <= w_sub_d;
            r_s1_chk   <= w_chk_d;
            for (int c = 0; c < NCH; c++) begin
                r_s1_a[c]    <= w_a_d[c];
                r_s1_b[c]    <= w_b_d[c];
                r_s1_addr[c] <= w_addr[c];
            end
            if (w_clr_go) begin
                r_ovf <= '0;
            end else begin
                r_ovf <= r_ovf | (r_s1_valid & w_res_ovf);
            end
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (clr_start) begin
                        r_state <= StClear;
                        r_cnt   <= '0;
                    end
                end
                StClear: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
